// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the memory arbiter.
//   arb_state_t   : arbiter FSM state encoding
//   MAX_WAIT_DEF  : default fetch starvation limit in cycles
//   WAIT_CNT_W    : width of the fetch wait counter
// ---------------------------------------------------------------------------
package riscv_pkg;

    localparam int unsigned MAX_WAIT_DEF = 4;
    localparam int unsigned WAIT_CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUS_IF = 2'd1,
        BUS_D  = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_starve_cnt.sv
// ---------------------------------------------------------------------------
// arb_starve_cnt
// Saturating count of cycles the fetch port has been kept waiting.
//   clk, reset : clock, asynchronous active-high reset
//   inc_i      : fetch waiting this cycle (count up, saturating at MAX_WAIT)
//   clr_i      : fetch being granted (clear; wins over inc_i)
//   starve_c   : count has reached MAX_WAIT (combinational from the register)
// ---------------------------------------------------------------------------
module arb_starve_cnt
    import riscv_pkg::*;
#(
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic starve_c
);

    localparam logic [WAIT_CNT_W-1:0] CNT_MAX = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] cnt_q;
    logic [WAIT_CNT_W-1:0] cnt_d;

    // Next count: clear on grant, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q < CNT_MAX)) begin
            cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starve_c = (cnt_q == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Arbitrates an instruction-fetch port and a data port onto one shared
// memory. Data wins ties unless the fetch port has waited MAX_WAIT cycles.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   if_req/if_addr             : fetch request (held until if_done)
//   if_done/if_rdata           : fetch completion pulse and read word
//   d_req/d_wr/d_addr/d_wdata  : data request (held until d_done)
//   d_done/d_rdata             : data completion pulse and read word
//   stall_if/stall_mem         : combinational stalls to the pipeline
//   mem_rd/mem_wr/mem_addr/mem_wdata : registered shared-memory command
//   mem_rdata/mem_ack          : shared-memory response (latency >= 1)
// ---------------------------------------------------------------------------
module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 9,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    arb_state_t state_q, state_d;

    logic              mem_rd_q,    mem_rd_d;
    logic              mem_wr_q,    mem_wr_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q,   if_done_d;
    logic              d_done_q,    d_done_d;
    logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;

    logic starve;
    logic wait_inc;
    logic wait_clr;

    // Fetch is waiting unless it owns the bus or is in its own RESP cycle
    // (if_done_q is high exactly during a fetch RESP).
    assign wait_inc = if_req && (state_q != BUS_IF) &&
                      !((state_q == RESP) && if_done_q);
    assign wait_clr = (state_q == IDLE) && (state_d == BUS_IF);

    arb_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_cnt (
        .clk      (clk),
        .reset    (reset),
        .inc_i    (wait_inc),
        .clr_i    (wait_clr),
        .starve_c (starve)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (d_req && !(starve && if_req)) begin
                    state_d = BUS_D;
                end else if (if_req) begin
                    state_d = BUS_IF;
                end
            end
            BUS_IF, BUS_D: begin
                if (mem_ack) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values: command loaded on grant, held through
    // the bus phase, dropped on ack; done pulses during RESP.
    always_comb begin
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        unique case (state_q)
            IDLE: begin
                mem_rd_d    = 1'b0;
                mem_wr_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
                if (state_d == BUS_D) begin
                    mem_rd_d    = ~d_wr;
                    mem_wr_d    = d_wr;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (state_d == BUS_IF) begin
                    mem_rd_d   = 1'b1;
                    mem_addr_d = if_addr;
                end
            end
            BUS_IF: begin
                if (mem_ack) begin
                    mem_rd_d    = 1'b0;
                    mem_addr_d  = '0;
                    if_done_d   = 1'b1;
                    if_rdata_d  = mem_rdata;
                end
            end
            BUS_D: begin
                if (mem_ack) begin
                    mem_rd_d    = 1'b0;
                    mem_wr_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    d_done_d    = 1'b1;
                    // Writes leave the last read word in place.
                    if (!mem_wr_q) begin
                        d_rdata_d = mem_rdata;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_rd    = mem_rd_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

    assign stall_if  = if_req & ~if_done_q;
    assign stall_mem = d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_arbiter with a small memory responder and
// scoreboard queues of expected read words.
module tb_mem_arbiter;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              stall_if;
    logic              stall_mem;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    mem_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] if_exp_q[$];
    logic [DATA_W-1:0] d_exp_q[$];

    // Power-on contents of the memory model.
    function automatic logic [31:0] init_val(input logic [8:0] a);
        if (a == 9'h010) return 32'h0050_0093;
        if (a == 9'h1FF) return 32'hCAFE_F00D;
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Memory responder: acks ack_dly cycles after a command first appears.
    int          ack_dly = 0;
    bit          resp_en = 1'b1;
    int          busy    = 0;
    logic        rsp_ack = 1'b0;
    logic        man_ack = 1'b0;
    logic [31:0] rsp_data = '0;
    logic [31:0] wmem   [0:511];
    bit          wvalid [0:511];

    always @(negedge clk) begin
        if (rsp_ack) begin
            rsp_ack = 1'b0;
            busy    = 0;
        end else if (resp_en && (mem_rd || mem_wr)) begin
            if (busy >= ack_dly) begin
                rsp_ack = 1'b1;
                if (mem_wr) begin
                    wmem[mem_addr]   = mem_wdata;
                    wvalid[mem_addr] = 1'b1;
                    rsp_data         = '0;
                end else begin
                    rsp_data = wvalid[mem_addr] ? wmem[mem_addr] : init_val(mem_addr);
                end
            end else begin
                busy++;
            end
        end else begin
            busy = 0;
        end
    end

    assign mem_ack   = rsp_ack | man_ack;
    assign mem_rdata = rsp_data;

    // Done-pulse counters and rd/wr overlap flag, sampled on the clock edge.
    int if_done_cnt  = 0;
    int d_done_cnt   = 0;
    bit overlap_seen = 1'b0;

    always @(posedge clk) begin
        if (if_done)          if_done_cnt  <= if_done_cnt + 1;
        if (d_done)           d_done_cnt   <= d_done_cnt + 1;
        if (mem_rd && mem_wr) overlap_seen <= 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check_if(input string tag);
        logic [31:0] exp;
        if (if_exp_q.size() > 0) exp = if_exp_q.pop_front();
        else                     exp = 'x;
        check(tag, 64'(if_rdata), 64'(exp));
    endtask

    task automatic sb_check_d(input string tag);
        logic [31:0] exp;
        if (d_exp_q.size() > 0) exp = d_exp_q.pop_front();
        else                    exp = 'x;
        check(tag, 64'(d_rdata), 64'(exp));
    endtask

    // Bounded wait for a done pulse; lat = negedges waited, -1 on timeout.
    task automatic wait_done(input bit want_d, input int budget, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(want_d ? d_done : if_done) && lat < budget);
        if (!(want_d ? d_done : if_done)) lat = -1;
    endtask

    initial begin
        int lat;
        int nd;
        int dcnt0;
        bit got_if;

        reset   = 1'b1;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_wr    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        repeat (2) @(negedge clk);

        // Reset state.
        check("rst if_done",   64'(if_done),   64'(0));
        check("rst d_done",    64'(d_done),    64'(0));
        check("rst mem_rd",    64'(mem_rd),    64'(0));
        check("rst mem_wr",    64'(mem_wr),    64'(0));
        check("rst mem_addr",  64'(mem_addr),  64'(0));
        check("rst mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst if_rdata",  64'(if_rdata),  64'(0));
        check("rst d_rdata",   64'(d_rdata),   64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single fetch, ack on the third bus cycle.
        ack_dly = 2;
        if_addr = 9'h010;
        if_req  = 1'b1;
        if_exp_q.push_back(32'h0050_0093);
        #1;
        check("fetch stall_if high", 64'(stall_if), 64'(1));
        @(negedge clk);
        check("fetch mem_rd",   64'(mem_rd),   64'(1));
        check("fetch mem_wr",   64'(mem_wr),   64'(0));
        check("fetch mem_addr", 64'(mem_addr), 64'(9'h010));
        wait_done(1'b0, 20, lat);
        check("fetch latency", 64'(lat), 64'(3));
        sb_check_if("fetch if_rdata");
        if_req = 1'b0;
        @(negedge clk);
        check("fetch stall_if low", 64'(stall_if), 64'(0));
        check("fetch done single",  64'(if_done),  64'(0));
        check("fetch bus released", 64'(mem_rd),   64'(0));
        @(negedge clk);
        check("fetch done count",   64'(if_done_cnt), 64'(1));

        // Simultaneous fetch and data write: data first, then fetch.
        ack_dly = 1;
        if_addr = 9'h030;
        if_req  = 1'b1;
        d_addr  = 9'h020;
        d_wdata = 32'hDEAD_BEEF;
        d_wr    = 1'b1;
        d_req   = 1'b1;
        if_exp_q.push_back(init_val(9'h030));
        @(negedge clk);
        check("sim mem_wr",    64'(mem_wr),    64'(1));
        check("sim mem_rd",    64'(mem_rd),    64'(0));
        check("sim mem_addr",  64'(mem_addr),  64'(9'h020));
        check("sim mem_wdata", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
        wait_done(1'b1, 20, lat);
        check("sim write latency",   64'(lat),         64'(2));
        check("sim d_rdata on write", 64'(d_rdata),    64'(0));
        check("sim fetch not yet",   64'(if_done_cnt), 64'(1));
        d_req = 1'b0;
        wait_done(1'b0, 20, lat);
        check("sim fetch latency", 64'(lat), 64'(4));
        sb_check_if("sim if_rdata");
        if_req = 1'b0;
        @(negedge clk);

        // Read back the written word with a same-cycle ack.
        ack_dly = 0;
        d_wr    = 1'b0;
        d_addr  = 9'h020;
        d_req   = 1'b1;
        d_exp_q.push_back(32'hDEAD_BEEF);
        wait_done(1'b1, 20, lat);
        check("readback latency", 64'(lat), 64'(2));
        sb_check_d("readback d_rdata");
        d_req = 1'b0;
        @(negedge clk);

        // Starvation: data held high back-to-back, fetch wins at wait_cnt 4.
        ack_dly = 0;
        if_addr = 9'h040;
        if_req  = 1'b1;
        d_wr    = 1'b0;
        d_addr  = 9'h100;
        d_req   = 1'b1;
        nd      = 0;
        got_if  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (d_done) begin
                nd++;
                check("starve d_rdata", 64'(d_rdata), 64'(init_val(9'h100)));
            end
            if (if_done) begin
                got_if = 1'b1;
                check("starve if_rdata", 64'(if_rdata), 64'(init_val(9'h040)));
                break;
            end
        end
        check("starve fetch granted", 64'(got_if), 64'(1));
        check("starve data before fetch", 64'(nd), 64'(2));
        if_req = 1'b0;
        wait_done(1'b1, 20, lat);
        check("starve data after fetch", 64'(lat), 64'(3));
        d_req = 1'b0;
        @(negedge clk);

        // Reset in the middle of a data write, memory never acks.
        resp_en = 1'b0;
        dcnt0   = d_done_cnt;
        d_wr    = 1'b1;
        d_addr  = 9'h055;
        d_wdata = 32'h1234_5678;
        d_req   = 1'b1;
        @(negedge clk);
        check("rstmid mem_wr before", 64'(mem_wr), 64'(1));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rstmid mem_wr",    64'(mem_wr),    64'(0));
        check("rstmid mem_addr",  64'(mem_addr),  64'(0));
        check("rstmid mem_wdata", 64'(mem_wdata), 64'(0));
        check("rstmid if_rdata",  64'(if_rdata),  64'(0));
        check("rstmid d_rdata",   64'(d_rdata),   64'(0));
        check("rstmid d_done",    64'(d_done),    64'(0));
        d_req = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        man_ack = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid late ack no done", 64'(d_done_cnt), 64'(dcnt0));
        check("rstmid idle mem_wr",      64'(mem_wr),     64'(0));
        check("rstmid idle mem_rd",      64'(mem_rd),     64'(0));
        resp_en = 1'b1;

        // Same-cycle ack read of the top address; held request waits for IDLE.
        ack_dly = 0;
        d_wr    = 1'b0;
        d_addr  = 9'h1FF;
        d_req   = 1'b1;
        d_exp_q.push_back(init_val(9'h1FF));
        wait_done(1'b1, 20, lat);
        check("top latency", 64'(lat), 64'(2));
        sb_check_d("top d_rdata");
        check("top resp no bus", 64'(mem_rd), 64'(0));
        d_exp_q.push_back(init_val(9'h1FF));
        @(negedge clk);
        check("top idle no done", 64'(d_done), 64'(0));
        check("top idle no bus",  64'(mem_rd), 64'(0));
        @(negedge clk);
        check("top regrant mem_rd",   64'(mem_rd),   64'(1));
        check("top regrant mem_addr", 64'(mem_addr), 64'(9'h1FF));
        wait_done(1'b1, 20, lat);
        check("top regrant latency", 64'(lat), 64'(1));
        sb_check_d("top regrant d_rdata");
        d_req = 1'b0;
        @(negedge clk);

        check("no rd/wr overlap", 64'(overlap_seen), 64'(0));
        check("if scoreboard empty", 64'(if_exp_q.size()), 64'(0));
        check("d scoreboard empty",  64'(d_exp_q.size()),  64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
